// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a small in-order instruction buffer.
// Optional retired-fetch counter on the fetch_count port is built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [63:0] ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [63:0]        pc_r;
    logic [63:0]        pc_nxt_s;
    logic [63:0]        addr_r;
    logic [63:0]        addr_nxt_s;
    logic               req_r;
    logic               req_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [31:0]        buf_instr_r [BUF_DEPTH];
    logic [63:0]        buf_pc_r    [BUF_DEPTH];
    logic               full_s;
    logic               push_s;
    logic               pop_s;

    assign full_s = (count_r == DEPTH_C);
    // Flush wins over both push and pop; a full buffer only accepts data when it is popped the same cycle.
    assign pop_s  = (count_r != {CNT_W{1'b0}}) & instr_ready & ~redirect;
    assign push_s = (state_r == FETCH) & imem_ack & ~redirect & (~full_s | pop_s);

    // Occupancy after this cycle's flush/push/pop.
    always_comb begin
        count_nxt_s = count_r;
        if (redirect) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else begin
            count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Next state, next fetch PC and the address/request presented to memory.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        if (redirect) begin
            pc_nxt_s = redirect_pc & ALIGN_MASK;
        end else if (push_s) begin
            pc_nxt_s = pc_r + 64'd4;
        end else begin
            pc_nxt_s = pc_r;
        end
        case (state_r)
            IDLE: begin
                state_nxt_s = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    state_nxt_s = imem_ack ? FETCH : DROP;
                end else if (push_s) begin
                    state_nxt_s = (count_nxt_s < DEPTH_C) ? FETCH : STALL;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            STALL: begin
                if (redirect) begin
                    state_nxt_s = FETCH;
                end else if (count_nxt_s < DEPTH_C) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = STALL;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        // While dropping, the stale request must stay on the bus at its original address.
        if (state_nxt_s == DROP) begin
            addr_nxt_s = addr_r;
        end else begin
            addr_nxt_s = pc_nxt_s;
        end
        req_nxt_s = (state_nxt_s == FETCH) || (state_nxt_s == DROP);
    end

    // FSM state, fetch PC and registered memory request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            addr_r  <= RESET_PC;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            addr_r  <= addr_nxt_s;
            req_r   <= req_nxt_s;
        end
    end

    // Buffer occupancy and read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (redirect) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Buffer storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr_r[i] <= 32'h0;
                buf_pc_r[i]    <= 64'h0;
            end
        end else if (push_s) begin
            buf_instr_r[wr_ptr_r] <= imem_rdata;
            buf_pc_r[wr_ptr_r]    <= pc_r;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign instr       = buf_instr_r[rd_ptr_r];
    assign instr_pc    = buf_pc_r[rd_ptr_r];
    assign instr_valid = (count_r != {CNT_W{1'b0}});

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count_r;

    // Retired-fetch counter, one per instruction handed to the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_r <= 32'h0;
        end else if (pop_s) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end
    end

    assign fetch_count = fetch_count_r;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a behavioural fetch model predicts requests and buffered words.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;

    logic        w_ack = 1'b1;
    logic        w_ready = 1'b1;
    logic        w_redirect = 1'b0;
    logic [63:0] w_redirect_pc = 64'h0;
    logic [31:0] w_rdata = 32'h0000_0013;
    logic        w_req;
    logic [63:0] w_addr;
    logic [31:0] w_instr;
    logic [63:0] w_instr_pc;
    logic        w_valid;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] w_fetch_count;
`endif

    instr_fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_pc(redirect_pc)
`ifdef IFU_PERF_CNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    instr_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .instr(w_instr), .instr_pc(w_instr_pc),
        .instr_valid(w_valid), .instr_ready(w_ready), .redirect(w_redirect),
        .redirect_pc(w_redirect_pc)
`ifdef IFU_PERF_CNT_EN
        , .fetch_count(w_fetch_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    typedef enum int {M_IDLE, M_FETCH, M_STALL, M_DROP} mst_t;
    localparam int DEPTH = 2;
    mst_t        m_st;
    logic [63:0] m_pc;
    logic [63:0] m_addr;
    logic [95:0] sb[$];
    logic [31:0] m_cnt;
    logic [63:0] w_pc;
    bit          w_started;

    task automatic model_reset();
        m_st = M_IDLE;
        m_pc = 64'h0;
        m_addr = 64'h0;
        sb.delete();
        m_cnt = 32'h0;
        w_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        w_started = 1'b0;
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        bit m_req;
        bit ack;
        bit pop;
        logic [95:0] hd;
        @(negedge clk);
        if (!rst_n) begin
            check_eq("rst_req", imem_req, 1'b0);
            check_eq("rst_addr", imem_addr, 64'h0);
            check_eq("rst_valid", instr_valid, 1'b0);
            check_eq("rst_instr", instr, 32'h0);
            check_eq("rst_instr_pc", instr_pc, 64'h0);
            check_eq("rst_wrap_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFF8);
`ifdef IFU_PERF_CNT_EN
            check_eq("rst_fetch_count", fetch_count, 32'h0);
`endif
            model_reset();
        end else begin
            m_req = (m_st == M_FETCH) || (m_st == M_DROP);
            check_eq("imem_req", imem_req, m_req);
            if (m_req) check_eq("imem_addr", imem_addr, m_addr);
            check_eq("instr_valid", instr_valid, sb.size() != 0);
`ifdef IFU_PERF_CNT_EN
            check_eq("fetch_count", fetch_count, m_cnt);
`endif
            if (w_started) begin
                check_eq("wrap_req", w_req, 1'b1);
                check_eq("wrap_addr", w_addr, w_pc);
                w_pc = w_pc + 64'd4;
            end else begin
                check_eq("wrap_idle_req", w_req, 1'b0);
                w_started = 1'b1;
            end
            ack = imem_ack && m_req;
            pop = instr_ready && (sb.size() != 0) && !redirect;
            if (pop) begin
                hd = sb.pop_front();
                check_eq("instr", instr, hd[95:64]);
                check_eq("instr_pc", instr_pc, hd[63:0]);
                m_cnt = m_cnt + 32'd1;
            end
            case (m_st)
                M_IDLE: m_st = M_FETCH;
                M_FETCH: begin
                    if (redirect) begin
                        sb.delete();
                        m_pc = redirect_pc & 64'hFFFF_FFFF_FFFF_FFFC;
                        m_st = ack ? M_FETCH : M_DROP;
                    end else if (ack) begin
                        sb.push_back({imem_rdata, m_pc});
                        m_pc = m_pc + 64'd4;
                        m_st = (sb.size() < DEPTH) ? M_FETCH : M_STALL;
                    end
                end
                M_STALL: begin
                    if (redirect) begin
                        sb.delete();
                        m_pc = redirect_pc & 64'hFFFF_FFFF_FFFF_FFFC;
                        m_st = M_FETCH;
                    end else if (sb.size() < DEPTH) begin
                        m_st = M_FETCH;
                    end
                end
                default: begin
                    if (redirect) begin
                        sb.delete();
                        m_pc = redirect_pc & 64'hFFFF_FFFF_FFFF_FFFC;
                    end
                    if (ack) m_st = M_FETCH;
                end
            endcase
            if (m_st != M_DROP) m_addr = m_pc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit ack, input bit rdy, input bit redir, input logic [63:0] rpc,
                       input logic [31:0] data);
        imem_ack = ack;
        instr_ready = rdy;
        redirect = redir;
        redirect_pc = rpc;
        imem_rdata = data;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 64'h0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;

        // Streaming with constant data: one fetch per cycle.
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, 64'h0, 32'h015A04B3);

        // Back-pressure: two pushes fill the buffer, one pop restarts fetch at 0x8.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 64'h0, $urandom);
        cyc(1'b1, 1'b1, 1'b0, 64'h0, $urandom);
        check_eq("restart_addr", imem_addr, 64'h8);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 64'h0, $urandom);

        // Asynchronous reset with two buffered entries, then a late ack during reset.
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", instr_valid, 1'b0);
        check_eq("async_rst_req", imem_req, 1'b0);
        model_reset();
        imem_ack = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        // Redirect while the request at 0x10 is pending; its ack arrives two cycles later.
        guard = 0;
        while (!(m_st == M_FETCH && m_addr == 64'h10) && guard < 20) begin
            cyc(1'b1, 1'b1, 1'b0, 64'h0, $urandom);
            guard++;
        end
        check_eq("reach_0x10", m_addr, 64'h10);
        cyc(1'b0, 1'b1, 1'b1, 64'h103, $urandom);
        cyc(1'b0, 1'b1, 1'b0, 64'h0, $urandom);
        cyc(1'b1, 1'b1, 1'b0, 64'h0, 32'hDEAD_BEEF);
        check_eq("redir_addr", imem_addr, 64'h100);
        check_eq("redir_empty", instr_valid, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 64'h0, $urandom);

        // Five pops, then reset clears everything including the counter.
        do_reset();
        guard = 0;
        while (m_cnt < 32'd5 && guard < 20) begin
            cyc(1'b1, 1'b1, 1'b0, 64'h0, $urandom);
            guard++;
        end
        check_eq("five_pops", m_cnt, 32'd5);
        step();
        do_reset();

        // Random ack, back-pressure and redirects.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                {$urandom, $urandom}, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
